// File: rtl/des_ip_stage.sv
// des_ip_stage
//   Applies the DES initial permutation IP to each accepted 64-bit block and
//   buffers the result in a 2-entry FIFO, presenting L0/R0 to the next stage.
//
// Ports
//   clk        single clock, rising-edge state updates
//   rst        synchronous active-high reset
//   in_valid   upstream offers in_data (bit 63 = DES bit 1)
//   in_ready   room for one more block (occupancy < 2)
//   in_data    64-bit plaintext/ciphertext block
//   out_valid  head entry present
//   out_ready  downstream consumes the head entry
//   out_l      L0 = upper half of IP(block)
//   out_r      R0 = lower half of IP(block)
//   blk_cnt    accepted-block counter, wraps silently
//   chk_err    sticky self-check failure flag
//
// Handshake: a transfer happens on a port exactly on a rising edge where
// valid && ready; ready never depends combinationally on the other side's
// valid, and offered data is only captured on a transfer.
//
// Optional feature: define DES_IP_SELFCHECK_EN to pass every accepted block
// back through FP and flag any mismatch with in_data on chk_err. Without it
// chk_err is tied low and no check logic exists.
module des_ip_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [63:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_l,
  output logic [31:0]      out_r,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             chk_err
);

  // DES bit number (1 = MSB) that feeds output bit position pos (1..64).
  // Rows of the IP table start at 58,60,62,64,57,59,61,63 and step down by 8.
  function automatic int ip_src(input int pos);
    int row;
    int col;
    int base;
    row  = (pos - 1) / 8;
    col  = (pos - 1) % 8;
    base = (row < 4) ? (58 + 2 * row) : (57 + 2 * (row - 4));
    return base - 8 * col;
  endfunction

  function automatic logic [63:0] des_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int p = 1; p <= 64; p++) begin
      y[6'(64 - p)] = x[6'(64 - ip_src(p))];
    end
    return y;
  endfunction

  logic [63:0] mem [2];
  logic        wr_ptr;
  logic        rd_ptr;
  logic [1:0]  occ;
  logic        push;
  logic        pop;
  logic [63:0] ip_word;

  assign ip_word   = des_ip(in_data);
  assign in_ready  = (occ != 2'd2);
  assign out_valid = (occ != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_l     = mem[rd_ptr][63:32];
  assign out_r     = mem[rd_ptr][31:0];

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= ip_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      occ     <= 2'd0;
      blk_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr  <= ~wr_ptr;
        blk_cnt <= blk_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

`ifdef DES_IP_SELFCHECK_EN
  // FP is the inverse mapping: the bit IP moved to position p goes back to
  // its source position.
  function automatic logic [63:0] des_fp(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int p = 1; p <= 64; p++) begin
      y[6'(64 - ip_src(p))] = x[6'(64 - p)];
    end
    return y;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      chk_err <= 1'b0;
    end else if (push && (des_fp(ip_word) != in_data)) begin
      chk_err <= 1'b1;
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_des_ip_stage.sv
module tb_des_ip_stage;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [63:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_l;
  logic [31:0]      out_r;
  logic [CNT_W-1:0] blk_cnt;
  logic             chk_err;

  int checks;
  int failures;

  // Reference model: queue of expected permuted words plus a counter.
  logic [63:0]      exp_q[$];
  logic [CNT_W-1:0] exp_cnt;

  // FIPS 46-3 IP table, entry i gives the source bit for output bit i+1.
  int ip_tab[64] = '{58, 50, 42, 34, 26, 18, 10, 2,
                     60, 52, 44, 36, 28, 20, 12, 4,
                     62, 54, 46, 38, 30, 22, 14, 6,
                     64, 56, 48, 40, 32, 24, 16, 8,
                     57, 49, 41, 33, 25, 17,  9, 1,
                     59, 51, 43, 35, 27, 19, 11, 3,
                     61, 53, 45, 37, 29, 21, 13, 5,
                     63, 55, 47, 39, 31, 23, 15, 7};

  des_ip_stage #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_l     (out_l),
    .out_r     (out_r),
    .blk_cnt   (blk_cnt),
    .chk_err   (chk_err)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_ip(input logic [63:0] x);
    logic [63:0] y;
    y = '0;
    for (int i = 0; i < 64; i++) begin
      y[6'(63 - i)] = x[6'(64 - ip_tab[i])];
    end
    return y;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- driver ----------------
  // Called just after a falling edge: drives one cycle of inputs, lets the
  // rising edge happen, updates the model, and returns at the next falling
  // edge where outputs are sampled.
  task automatic step(input logic v, input logic [63:0] d, input logic r);
    logic do_push;
    logic do_pop;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    do_push = !rst && v && (exp_q.size() < 2);
    do_pop  = !rst && r && (exp_q.size() > 0);
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      exp_cnt = '0;
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) begin
        exp_q.push_back(ref_ip(d));
        exp_cnt = exp_cnt + CNT_W'(1);
      end
    end
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    step(1'b0, 64'h0, 1'b0);
    step(1'b0, 64'h0, 1'b0);
    rst = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_dut();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (blk_cnt !== '0) begin
      failures++; $display("FAIL reset_blk_cnt: got %0d expected 0", blk_cnt);
    end
    checks++;
    if (chk_err !== 1'b0) begin
      failures++; $display("FAIL reset_chk_err: got %b expected 0", chk_err);
    end
  endtask

  task automatic test_known_vector();
    step(1'b1, 64'h0123456789ABCDEF, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      failures++; $display("FAIL kv_out_valid: got %b expected 1", out_valid);
    end
    checks++;
    if (out_l !== 32'hCC00CCFF) begin
      failures++; $display("FAIL kv_out_l: got %h expected cc00ccff", out_l);
    end
    checks++;
    if (out_r !== 32'hF0AAF0AA) begin
      failures++; $display("FAIL kv_out_r: got %h expected f0aaf0aa", out_r);
    end
    checks++;
    if (blk_cnt !== CNT_W'(1)) begin
      failures++; $display("FAIL kv_blk_cnt: got %0d expected 1", blk_cnt);
    end
    step(1'b0, 64'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL kv_drain: got out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 64'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || {out_l, out_r} !== 64'h0) begin
      failures++; $display("FAIL b2b_first: got v=%b %h expected v=1 0", out_valid, {out_l, out_r});
    end
    step(1'b1, 64'hFFFFFFFFFFFFFFFF, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || {out_l, out_r} !== 64'hFFFFFFFFFFFFFFFF) begin
      failures++; $display("FAIL b2b_second: got v=%b %h expected v=1 ffffffffffffffff", out_valid, {out_l, out_r});
    end
    step(1'b0, 64'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++; $display("FAIL b2b_drain: got out_valid %b expected 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] blk [3];
    logic [CNT_W-1:0] cnt0;
    for (int i = 0; i < 3; i++) blk[i] = rand64();
    cnt0 = exp_cnt;
    step(1'b1, blk[0], 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_ready_after1: got %b expected 1", in_ready);
    end
    step(1'b1, blk[1], 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL bp_ready_after2: got %b expected 0", in_ready);
    end
    step(1'b1, blk[2], 1'b0);
    checks++;
    if (blk_cnt !== cnt0 + CNT_W'(2)) begin
      failures++; $display("FAIL bp_third_held: got cnt %0d expected %0d", blk_cnt, cnt0 + CNT_W'(2));
    end
    checks++;
    if ({out_l, out_r} !== ref_ip(blk[0])) begin
      failures++; $display("FAIL bp_head_stable: got %h expected %h", {out_l, out_r}, ref_ip(blk[0]));
    end
    // Third block stays offered; downstream opens up.
    step(1'b1, blk[2], 1'b1);
    checks++;
    if ({out_l, out_r} !== ref_ip(blk[1])) begin
      failures++; $display("FAIL bp_order2: got %h expected %h", {out_l, out_r}, ref_ip(blk[1]));
    end
    step(1'b1, blk[2], 1'b1);
    checks++;
    if (out_valid !== 1'b1 || {out_l, out_r} !== ref_ip(blk[2])) begin
      failures++; $display("FAIL bp_order3: got v=%b %h expected v=1 %h", out_valid, {out_l, out_r}, ref_ip(blk[2]));
    end
    step(1'b0, 64'h0, 1'b1);
    // Pop on an empty FIFO is ignored.
    step(1'b0, 64'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || blk_cnt !== cnt0 + CNT_W'(3)) begin
      failures++; $display("FAIL bp_empty_pop: got v=%b r=%b cnt=%0d expected v=0 r=1 cnt=%0d",
                           out_valid, in_ready, blk_cnt, cnt0 + CNT_W'(3));
    end
  endtask

  task automatic test_full_simul();
    logic [63:0] d;
    step(1'b1, rand64(), 1'b0);
    step(1'b1, rand64(), 1'b0);
    // Full: only the pop can happen even with in_valid high.
    d = rand64();
    step(1'b1, d, 1'b1);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || {out_l, out_r} !== exp_q[0]) begin
      failures++; $display("FAIL full_pop_only: got r=%b v=%b %h expected r=1 v=1 %h",
                           in_ready, out_valid, {out_l, out_r}, exp_q[0]);
    end
    step(1'b1, d, 1'b0);
    checks++;
    if (in_ready !== 1'b0) begin
      failures++; $display("FAIL full_refill: got in_ready %b expected 0", in_ready);
    end
    // Drop to one entry, then push and pop together.
    step(1'b0, 64'h0, 1'b1);
    step(1'b1, rand64(), 1'b1);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b1 || {out_l, out_r} !== exp_q[0]) begin
      failures++; $display("FAIL simul_push_pop: got r=%b v=%b %h expected r=1 v=1 %h",
                           in_ready, out_valid, {out_l, out_r}, exp_q[0]);
    end
    step(1'b0, 64'h0, 1'b1);
  endtask

  task automatic test_random();
    int accepted;
    int cycles;
    logic v;
    logic r;
    accepted = 0;
    cycles   = 0;
    while (accepted < 100 && cycles < 3000) begin
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 6);
      if (v && exp_q.size() < 2) accepted++;
      step(v, rand64(), r);
      cycles++;
      checks++;
      if (out_valid !== (exp_q.size() != 0) || in_ready !== (exp_q.size() < 2)) begin
        failures++; $display("FAIL rnd_flags cyc %0d: got v=%b r=%b expected occupancy %0d",
                             cycles, out_valid, in_ready, exp_q.size());
      end
      if (exp_q.size() != 0) begin
        checks++;
        if ({out_l, out_r} !== exp_q[0]) begin
          failures++; $display("FAIL rnd_data cyc %0d: got %h expected %h", cycles, {out_l, out_r}, exp_q[0]);
        end
      end
      checks++;
      if (blk_cnt !== exp_cnt || chk_err !== 1'b0) begin
        failures++; $display("FAIL rnd_cnt cyc %0d: got cnt=%0d err=%b expected cnt=%0d err=0",
                             cycles, blk_cnt, chk_err, exp_cnt);
      end
    end
    checks++;
    if (accepted < 100) begin
      failures++; $display("FAIL rnd_budget: got %0d accepted expected 100", accepted);
    end
    for (int i = 0; i < 4 && exp_q.size() != 0; i++) step(1'b0, 64'h0, 1'b1);
    checks++;
    if (out_valid !== 1'b0 || exp_q.size() != 0) begin
      failures++; $display("FAIL rnd_drain: got out_valid %b expected 0 (model left %0d)", out_valid, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [63:0] k;
    reset_dut();
    for (int i = 0; i < 3; i++) step(1'b1, rand64(), 1'b1);
    step(1'b0, 64'h0, 1'b1);
    step(1'b1, rand64(), 1'b0);
    step(1'b1, rand64(), 1'b0);
    checks++;
    if (blk_cnt !== CNT_W'(5) || in_ready !== 1'b0) begin
      failures++; $display("FAIL rm_setup: got cnt=%0d r=%b expected cnt=5 r=0", blk_cnt, in_ready);
    end
    // Reset wins over a simultaneous pop.
    rst = 1'b1;
    step(1'b1, rand64(), 1'b1);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || blk_cnt !== '0) begin
      failures++; $display("FAIL rm_after_rst: got v=%b r=%b cnt=%0d expected v=0 r=1 cnt=0",
                           out_valid, in_ready, blk_cnt);
    end
    k = rand64();
    step(1'b1, k, 1'b0);
    checks++;
    if (out_valid !== 1'b1 || {out_l, out_r} !== ref_ip(k) || blk_cnt !== CNT_W'(1)) begin
      failures++; $display("FAIL rm_next_block: got v=%b %h cnt=%0d expected v=1 %h cnt=1",
                           out_valid, {out_l, out_r}, blk_cnt, ref_ip(k));
    end
    step(1'b0, 64'h0, 1'b1);
  endtask

  task automatic test_wrap();
    reset_dut();
    for (int i = 0; i < 17; i++) step(1'b1, rand64(), 1'b1);
    checks++;
    if (blk_cnt !== CNT_W'(1)) begin
      failures++; $display("FAIL wrap_cnt: got %0d expected 1", blk_cnt);
    end
    checks++;
    if (chk_err !== 1'b0) begin
      failures++; $display("FAIL wrap_chk_err: got %b expected 0", chk_err);
    end
    step(1'b0, 64'h0, 1'b1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks    = 0;
    failures  = 0;
    exp_cnt   = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 64'h0;
    out_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_known_vector();
    test_back_to_back();
    test_backpressure();
    test_full_simul();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
